// File: rtl/gfx_ser_pkg.sv
// Shared types and default geometry for the pixel serializer and tile fetch path.
package gfx_ser_pkg;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_t;

   localparam int GFX_PLANES = 3;
   localparam int GFX_WIDTH  = 8;

endpackage

// File: rtl/gfx_plane_shifter.sv
// One bitplane shift register: parallel load, shift left/right, serial pixel out.
module gfx_plane_shifter
   import gfx_ser_pkg::*;
#(
   parameter int WIDTH = GFX_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bits,
   input  logic             shift_en,
   input  logic             dir_right,
   output logic             sout
);

   logic [WIDTH-1:0] sh;

   // Load wins over shift; direction picks which end is the current pixel.
   always_ff @(posedge clk) begin
      if (reset)
         sh <= '0;
      else if (load)
         sh <= load_bits;
      else if (shift_en)
         sh <= dir_right ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
   end

   assign sout = dir_right ? sh[0] : sh[WIDTH-1];

endmodule

// File: rtl/gfx_pixel_serializer.sv
// Parallel-to-serial pixel shifter: one-deep staging register feeding PLANES
// lockstep plane shifters, with per-word horizontal flip and gap-free streaming.
module gfx_pixel_serializer
   import gfx_ser_pkg::*;
#(
   parameter int PLANES = GFX_PLANES,
   parameter int WIDTH  = GFX_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cen,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [PLANES*WIDTH-1:0] load_data,
   input  logic                    load_flip,
   output logic [PLANES-1:0]       pix_out,
   output logic                    pix_valid,
   output logic                    starve
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   ser_state_t               state;
   logic [PLANES*WIDTH-1:0]  stage_data;
   logic                     stage_flip;
   logic                     stage_full;
   logic                     flip_q;
   logic [CW-1:0]            cnt;
   logic [PLANES-1:0]        sout;

   logic accept;
   logic last_pix;
   logic xfer;
   logic shift_en;

   // Ready is held low through reset so nothing is accepted on the reset edge.
   assign load_ready = !stage_full && !reset;
   assign accept     = load_valid && load_ready;
   assign last_pix   = (state == SER_SHIFT) && cen && (cnt == CNT_LAST);
   // Accept and transfer are mutually exclusive: accept needs staging empty, transfer needs it full.
   assign xfer       = stage_full && ((state == SER_IDLE) || last_pix);
   assign shift_en   = (state == SER_SHIFT) && cen && (cnt != CNT_LAST);

   // Staging, pixel counter, flip latch and the IDLE/SHIFT machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SER_IDLE;
         stage_data <= '0;
         stage_flip <= 1'b0;
         stage_full <= 1'b0;
         flip_q     <= 1'b0;
         cnt        <= '0;
         starve     <= 1'b0;
      end else begin
         starve <= 1'b0;
         if (accept) begin
            stage_data <= load_data;
            stage_flip <= load_flip;
            stage_full <= 1'b1;
         end
         if (xfer) begin
            stage_full <= 1'b0;
            flip_q     <= stage_flip;
            cnt        <= '0;
            state      <= SER_SHIFT;
         end else if (shift_en) begin
            cnt <= cnt + 1'b1;
         end else if (last_pix) begin
            state  <= SER_IDLE;
            starve <= 1'b1;
         end
      end
   end

   genvar p;
   generate
      for (p = 0; p < PLANES; p++) begin : g_plane
         gfx_plane_shifter #(.WIDTH(WIDTH)) u_shift (
            .clk       (clk),
            .reset     (reset),
            .load      (xfer),
            .load_bits (stage_data[p*WIDTH +: WIDTH]),
            .shift_en  (shift_en),
            .dir_right (flip_q),
            .sout      (sout[p])
         );
      end
   endgenerate

   assign pix_valid = (state == SER_SHIFT);
   assign pix_out   = pix_valid ? sout : '0;

endmodule

// File: tb/tb_gfx_pixel_serializer.sv
// Scoreboard bench for gfx_pixel_serializer: expected pixels queued at accept,
// compared and popped as the serializer advances.
module tb_gfx_pixel_serializer;
   import gfx_ser_pkg::*;

   localparam int P = GFX_PLANES;
   localparam int W = GFX_WIDTH;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cen = 1'b0;
   logic           load_valid = 1'b0;
   logic           load_flip = 1'b0;
   logic [P*W-1:0] load_data = '0;
   logic           load_ready;
   logic [P-1:0]   pix_out;
   logic           pix_valid;
   logic           starve;

   gfx_pixel_serializer #(.PLANES(P), .WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cen        (cen),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_flip  (load_flip),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid),
      .starve     (starve)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int cen_div = 1;
   int phase = 0;
   logic [P-1:0] q[$];
   int valid_cnt = 0, starve_cnt = 0, vld_rises = 0;
   int first_vld_cyc = 0, last_vld_cyc = 0, acc_cyc = 0, hold_run = 0;
   bit prev_vld = 0, first_px = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [P-1:0] exp_pix(input logic [P*W-1:0] d, input bit f, input int i);
      logic [P-1:0] r;
      for (int pl = 0; pl < P; pl++)
         r[pl] = f ? d[pl*W + i] : d[pl*W + W-1-i];
      return r;
   endfunction

   always @(posedge clk) cyc++;

   // Pixel enable: every clk, or one clk in cen_div.
   always @(posedge clk) begin
      #1;
      if (cen_div <= 1) cen = 1'b1;
      else begin
         cen   = (phase == 0);
         phase = (phase + 1) % cen_div;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (pix_valid) begin
            valid_cnt++;
            last_vld_cyc = cyc;
            if (!prev_vld) begin
               vld_rises++;
               first_vld_cyc = cyc;
               first_px = 1;
               hold_run = 0;
            end
            hold_run++;
            if (q.size() == 0) chk("pix_unexpected", pix_valid, 0);
            else begin
               chk("pix", pix_out, q[0]);
               if (cen) begin
                  if (cen_div > 1 && !first_px) chk("pix_hold", hold_run, cen_div);
                  first_px = 0;
                  hold_run = 0;
                  void'(q.pop_front());
               end
            end
         end else begin
            chk("pix_idle_zero", pix_out, 0);
         end
         if (starve) begin
            starve_cnt++;
            chk("starve_gap", cyc - last_vld_cyc, 1);
         end
         prev_vld = pix_valid;
      end else begin
         prev_vld = 0;
      end
   end

   task automatic load(input logic [P*W-1:0] d, input bit f);
      bit r;
      int n;
      n = 0;
      load_data = d;
      load_flip = f;
      load_valid = 1'b1;
      do begin
         @(negedge clk);
         r = load_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 100);
      load_valid = 1'b0;
      if (!r) chk("load_timeout", load_ready, 1);
      else begin
         acc_cyc = cyc;
         for (int i = 0; i < W; i++) q.push_back(exp_pix(d, f, i));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || pix_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) chk("drain_timeout", pix_valid | (q.size() != 0), 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int vb, sb, rb, n;
      logic [P*W-1:0] wa, wb;
      wa = {8'h00, 8'hFF, 8'hC0};
      wb = {8'h00, 8'hFF, 8'h0F};

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_out", pix_out, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_starve", starve, 0);
      chk("rst_load_ready", load_ready, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", load_ready, 1);

      // Single word, no flip, then flipped
      for (int f = 0; f < 2; f++) begin
         vb = valid_cnt; sb = starve_cnt; rb = vld_rises;
         load(wa, f[0]);
         drain();
         chk("w1_valid_len", valid_cnt - vb, 8);
         chk("w1_starve", starve_cnt - sb, 1);
         chk("w1_latency", first_vld_cyc - acc_cyc, 1);
         chk("w1_runs", vld_rises - rb, 1);
      end

      // Back-to-back words stream without a gap
      vb = valid_cnt; sb = starve_cnt; rb = vld_rises;
      load(wa, 1'b0);
      load(wb, 1'b0);
      chk("ready_while_staged", load_ready, 0);
      drain();
      chk("b2b_valid_len", valid_cnt - vb, 16);
      chk("b2b_starve", starve_cnt - sb, 1);
      chk("b2b_runs", vld_rises - rb, 1);

      // Slow pixel clock with load_flip toggling outside its word
      cen_div = 3;
      phase = 0;
      sb = starve_cnt; rb = vld_rises;
      load(wa, 1'b0);
      load(wb, 1'b1);
      repeat (12) begin
         load_flip = ~load_flip;
         @(posedge clk);
         #1;
      end
      drain();
      chk("slow_starve", starve_cnt - sb, 1);
      chk("slow_runs", vld_rises - rb, 1);
      cen_div = 1;

      // Reset mid-word with a word staged
      sb = starve_cnt;
      vb = valid_cnt;
      load(wa, 1'b0);
      load(wb, 1'b1);
      n = 0;
      while (valid_cnt - vb < 3 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("midrst_timeout", valid_cnt - vb, 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      chk("midrst_valid", pix_valid, 0);
      chk("midrst_pix", pix_out, 0);
      chk("midrst_starve", starve, 0);
      reset = 1'b0;
      vb = valid_cnt;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      chk("midrst_no_staged", valid_cnt - vb, 0);
      chk("midrst_no_starve", starve_cnt - sb, 0);
      chk("midrst_ready", load_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
